inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 152 +++++++++++++++
 tb/tb_inst_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word fetches to a 1-cycle-latency RAM and queues the returned words.
// Optional performance counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic                    inflight;
  logic [ADDR_WIDTH-1:0]   inflight_pc;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [DATA_WIDTH-1:0]   inst_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];

  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [CNT_W:0]          occupancy;
  logic [ADDR_WIDTH-1:0]   redirect_target;
  logic                    unused_redirect_lsbs;

  // Redirect targets are word aligned; the two low bits are dropped.
  assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Queued words plus the word still in the RAM pipeline form the credit check.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !redirect_valid;
  assign mem_addr   = fetch_pc;

  // Head outputs are gated so an empty queue presents zeros, whatever the storage holds.
  assign inst    = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc = inst_valid ? pc_mem[rd_ptr]   : '0;

  // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      FETCH: begin
        if (halt && !redirect_valid) begin
          state_nxt = HALTED;
        end
        issue = !halt && !redirect_valid &&
                (occupancy < (CNT_W+1)'(FIFO_DEPTH));
      end
      HALTED: begin
        if (!halt || redirect_valid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      inflight    <= issue;
      inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        // Flush: the inflight word is squashed simply by not pushing it.
        fetch_pc <= redirect_target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      inst_mem[wr_ptr] <= mem_dout;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (state == FETCH && !halt && !issue) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: two instances (RESET_PC 0x0000 and 0xFFF8),
// each fed by a behavioural 1-cycle-latency RAM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_ready;

  logic [15:0] mem_addr_a, mem_addr_b;
  logic [15:0] addr_q_a, addr_q_b;
  logic [31:0] mem_dout_a, mem_dout_b;
  logic        inst_valid_a, inst_valid_b;
  logic [31:0] inst_a, inst_b;
  logic [15:0] inst_pc_a, inst_pc_b;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetched_a, perf_stall_a, perf_fetched_b, perf_stall_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h1111_1111;
      16'h0004: return 32'h2222_2222;
      16'h0008: return 32'h3333_3333;
      default:  return {~a, a};
    endcase
  endfunction

  always @(posedge clk) begin
    addr_q_a <= mem_addr_a;
    addr_q_b <= mem_addr_b;
  end
  assign mem_dout_a = ram_word(addr_q_a);
  assign mem_dout_b = ram_word(addr_q_b);

  inst_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready), .inst(inst_a), .inst_pc(inst_pc_a)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetched(perf_fetched_a), .perf_stall(perf_stall_a)
`endif
  );

  inst_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(16'hFFF8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .halt(1'b0),
    .inst_valid(inst_valid_b), .inst_ready(1'b1), .inst(inst_b), .inst_pc(inst_pc_b)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetched(perf_fetched_b), .perf_stall(perf_stall_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in the first cycle with rst_n high (cycle R).
  task automatic do_reset();
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    repeat (2) step();
    check("rst valid",    32'(inst_valid_a), 32'd0);
    check("rst inst",     inst_a,            32'd0);
    check("rst inst_pc",  32'(inst_pc_a),    32'd0);
    check("rst mem_addr", 32'(mem_addr_a),   32'h0000);
    check("rst mem_addr_b", 32'(mem_addr_b), 32'hFFF8);
    rst_n = 1'b1;
  endtask

  initial begin
    inst_ready = 1'b1;

    // Reset release, sequential fetch, and address wrap on the second instance.
    do_reset();
    check("s1 R mem_addr", 32'(mem_addr_a), 32'h0000);
    check("s1 R valid",    32'(inst_valid_a), 32'd0);
    step();
    check("s1 R+1 valid",    32'(inst_valid_a), 32'd0);
    check("s1 R+1 mem_addr", 32'(mem_addr_a), 32'h0004);
    check("s1 R+1 b addr",   32'(mem_addr_b), 32'hFFFC);
    step();
    check("s1 R+2 valid", 32'(inst_valid_a), 32'd1);
    check("s1 R+2 inst",  inst_a,            32'h1111_1111);
    check("s1 R+2 pc",    32'(inst_pc_a),    32'h0000);
    check("s1 R+2 b pc",  32'(inst_pc_b),    32'hFFF8);
    step();
    check("s1 R+3 inst",  inst_a,            32'h2222_2222);
    check("s1 R+3 pc",    32'(inst_pc_a),    32'h0004);
    check("s1 R+3 b pc",  32'(inst_pc_b),    32'hFFFC);
    step();
    check("s1 R+4 inst",  inst_a,            32'h3333_3333);
    check("s1 R+4 pc",    32'(inst_pc_a),    32'h0008);
    check("s1 R+4 b pc",  32'(inst_pc_b),    32'h0000);
    check("s1 R+4 b inst", inst_b,           32'h1111_1111);
    step();
    check("s1 R+5 b pc",  32'(inst_pc_b),    32'h0004);
`ifdef INST_FETCH_PERF_EN
    check("s1 perf_fetched", perf_fetched_a, 32'd3);
`endif

    // Back-pressure: queue fills to exactly four, head stays put, then drains in order.
    do_reset();
    inst_ready = 1'b0;
    repeat (4) step();
    check("s2 R+4 pc",       32'(inst_pc_a),  32'h0000);
    check("s2 R+4 mem_addr", 32'(mem_addr_a), 32'h0010);
    step();
    check("s2 R+5 valid",    32'(inst_valid_a), 32'd1);
    check("s2 R+5 inst",     inst_a,          32'h1111_1111);
    check("s2 R+5 mem_addr", 32'(mem_addr_a), 32'h0010);
    repeat (4) step();
    check("s2 R+9 inst",     inst_a,          32'h1111_1111);
    check("s2 R+9 pc",       32'(inst_pc_a),  32'h0000);
    check("s2 R+9 mem_addr", 32'(mem_addr_a), 32'h0010);
    step();
`ifdef INST_FETCH_PERF_EN
    check("s2 perf_stall", perf_stall_a, 32'd6);
`endif
    inst_ready = 1'b1;
    check("s2 R+10 pc",       32'(inst_pc_a),  32'h0000);
    check("s2 R+10 mem_addr", 32'(mem_addr_a), 32'h0010);
    step();
    check("s2 R+11 pc",       32'(inst_pc_a),  32'h0004);
    check("s2 R+11 mem_addr", 32'(mem_addr_a), 32'h0010);
    step();
    check("s2 R+12 pc",       32'(inst_pc_a),  32'h0008);
    check("s2 R+12 mem_addr", 32'(mem_addr_a), 32'h0014);
    step();
    check("s2 R+13 pc",       32'(inst_pc_a),  32'h000C);
    step();
    check("s2 R+14 pc",       32'(inst_pc_a),  32'h0010);
    check("s2 R+14 inst",     inst_a,          32'hFFEF_0010);

    // Redirect with three queued entries and one inflight; low target bits are ignored.
    do_reset();
    inst_ready = 1'b0;
    repeat (4) step();
    check("s3 R+4 valid", 32'(inst_valid_a), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0102;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("s3 R+5 valid",    32'(inst_valid_a), 32'd0);
    check("s3 R+5 mem_addr", 32'(mem_addr_a), 32'h0100);
`ifdef INST_FETCH_PERF_EN
    check("s3 perf_fetched", perf_fetched_a, 32'd1);
`endif
    step();
    check("s3 R+6 valid",    32'(inst_valid_a), 32'd0);
    check("s3 R+6 mem_addr", 32'(mem_addr_a), 32'h0104);
    step();
    check("s3 R+7 valid", 32'(inst_valid_a), 32'd1);
    check("s3 R+7 pc",    32'(inst_pc_a),    32'h0100);
    check("s3 R+7 inst",  inst_a,            32'hFEFF_0100);
    step();
    check("s3 R+8 pc",    32'(inst_pc_a),    32'h0104);

    // Halt stops issue and drains the queue; redirect under halt re-enters FETCH.
    do_reset();
    inst_ready = 1'b1;
    repeat (3) step();
    halt = 1'b1;
    check("s4 R+3 pc", 32'(inst_pc_a), 32'h0004);
    step();
    check("s4 R+4 pc",       32'(inst_pc_a),  32'h0008);
    check("s4 R+4 mem_addr", 32'(mem_addr_a), 32'h000C);
    step();
    check("s4 R+5 valid",    32'(inst_valid_a), 32'd0);
    check("s4 R+5 mem_addr", 32'(mem_addr_a), 32'h000C);
    repeat (2) step();
    check("s4 R+7 valid",    32'(inst_valid_a), 32'd0);
    check("s4 R+7 mem_addr", 32'(mem_addr_a), 32'h000C);
`ifdef INST_FETCH_PERF_EN
    check("s4 perf_stall halt", perf_stall_a, 32'd0);
`endif
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0043;
    step();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    check("s4 R+9 mem_addr", 32'(mem_addr_a), 32'h0040);
    check("s4 R+9 valid",    32'(inst_valid_a), 32'd0);
    step();
    check("s4 R+10 mem_addr", 32'(mem_addr_a), 32'h0044);
`ifdef INST_FETCH_PERF_EN
    check("s4 perf_stall end", perf_stall_a, 32'd0);
`endif
    step();
    check("s4 R+11 valid", 32'(inst_valid_a), 32'd1);
    check("s4 R+11 pc",    32'(inst_pc_a),    32'h0040);
    check("s4 R+11 inst",  inst_a,            32'hFFBF_0040);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
